// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tracks in-flight register writes from EX through WB and
//                derives EX forwarding selects, WB->ID bypass requests,
//                load-use stalls and branch/jump flushes.
//                Optional performance counters: HAZARD_SCOREBOARD_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int STAGES       = 3,
    parameter int LOAD_STAGE   = 2,
    parameter int BRANCH_STAGE = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int FWD_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  flush,
    output logic [FWD_W-1:0]      ex_fwd_a,
    output logic [FWD_W-1:0]      ex_fwd_b,
    output logic                  id_wb_bypass_1,
    output logic                  id_wb_bypass_2,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
);

    // Index of the WB entry; a producer here is served by the ID bypass.
    localparam logic [FWD_W-1:0] LAST_IDX = FWD_W'(STAGES - 1);

    // Scoreboard entries: index 0 is EX, index STAGES-1 is WB.
    logic [STAGES-1:0]     sb_valid;
    logic [STAGES-1:0]     sb_load;
    logic [REG_ADDR_W-1:0] sb_rd [STAGES];

    logic             hit_a, hit_b;
    logic             load_a, load_b;
    logic [FWD_W-1:0] idx_a, idx_b;
    logic             need_a, need_b;
    logic             hazard_a, hazard_b;
    logic [FWD_W-1:0] sel_a, sel_b;
    logic             candidate;

    // Youngest-producer search: scanning from WB down to EX leaves the lowest
    // matching index, i.e. the most recent writer of each source.
    always_comb begin
        hit_a  = 1'b0;
        idx_a  = '0;
        load_a = 1'b0;
        hit_b  = 1'b0;
        idx_b  = '0;
        load_b = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (sb_valid[k] && (sb_rd[k] == id_rs1)) begin
                hit_a  = 1'b1;
                idx_a  = FWD_W'(k);
                load_a = sb_load[k];
            end
            if (sb_valid[k] && (sb_rd[k] == id_rs2)) begin
                hit_b  = 1'b1;
                idx_b  = FWD_W'(k);
                load_b = sb_load[k];
            end
        end
    end

    // Qualify matches: x0 never matches, unused sources and empty ID slots
    // never create dependencies.
    assign need_a = id_valid && id_rs1_used && (id_rs1 != '0) && hit_a;
    assign need_b = id_valid && id_rs2_used && (id_rs2 != '0) && hit_b;

    // A load whose data is not yet in a pipeline register cannot be forwarded.
    assign hazard_a = need_a && load_a && ((int'(idx_a) + 1) < LOAD_STAGE);
    assign hazard_b = need_b && load_b && ((int'(idx_b) + 1) < LOAD_STAGE);

    // Entry k moves to k+1 at the next edge, so that is where EX picks it up.
    assign sel_a = (need_a && (idx_a != LAST_IDX)) ? idx_a + FWD_W'(1) : '0;
    assign sel_b = (need_b && (idx_b != LAST_IDX)) ? idx_b + FWD_W'(1) : '0;

    assign id_wb_bypass_1 = need_a && (idx_a == LAST_IDX);
    assign id_wb_bypass_2 = need_b && (idx_b == LAST_IDX);

    // Flush outranks stall: the stalled instruction is being killed anyway.
    assign flush = redirect && enable;
    assign stall = !flush && (hazard_a || hazard_b);

    assign candidate = id_valid && id_reg_write && (id_rd != '0);

    // Advance the scoreboard and latch forwarding selects for the next EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sb_rd[i] <= '0;
            end
            ex_fwd_a <= '0;
            ex_fwd_b <= '0;
        end else if (enable) begin
            for (int i = 1; i < STAGES; i++) begin
                sb_valid[i] <= sb_valid[i-1] && !(flush && (i < BRANCH_STAGE));
                sb_load[i]  <= sb_load[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= candidate && !stall && !flush;
            sb_load[0]  <= id_mem_read;
            sb_rd[0]    <= id_rd;
            ex_fwd_a    <= (stall || flush) ? '0 : sel_a;
            ex_fwd_b    <= (stall || flush) ? '0 : sel_b;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (enable && stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Randomised scoreboard bench for hazard_scoreboard, with a
//                queue-based pipeline reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int STAGES       = 3;
    localparam int LOAD_STAGE   = 2;
    localparam int BRANCH_STAGE = 2;
    localparam int RW           = 5;
    localparam int FW           = 3;

    logic          clk = 1'b0;
    logic          rst, enable, id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, redirect;
    logic          stall, flush, id_wb_bypass_1, id_wb_bypass_2;
    logic [FW-1:0] ex_fwd_a, ex_fwd_b;
    logic [31:0]   stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE), .BRANCH_STAGE(BRANCH_STAGE),
        .REG_ADDR_W(RW), .FWD_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .redirect(redirect), .stall(stall),
        .flush(flush), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .id_wb_bypass_1(id_wb_bypass_1), .id_wb_bypass_2(id_wb_bypass_2),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ent_t;

    typedef struct {
        logic          stall, flush, b1, b2;
        logic [FW-1:0] fa, fb;
        logic [31:0]   sc, fc;
    } exp_t;

    // Reference model: in-flight instructions, youngest at the front.
    ent_t   pipe[$];
    int     m_fa, m_fb;
    longint m_sc, m_fc;
    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;

    function automatic int find_prod(int src);
        for (int k = 0; k < pipe.size(); k++)
            if (pipe[k].v && pipe[k].rd == src) return k;
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 0; e.rd = 0; e.ld = 0;
        pipe.delete();
        for (int i = 0; i < STAGES; i++) pipe.push_back(e);
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endtask

    // Drive one cycle, queue the expected outputs, then advance the model.
    task automatic step(bit v, int rs1, bit u1, int rs2, bit u2, int rd,
                        bit w, bit ld, bit redir, bit en, bit r);
        exp_t e;
        ent_t ne;
        int   k1, k2, s1, s2;
        bit   fl, st, hz;
        id_valid = v; id_rs1 = RW'(rs1); id_rs1_used = u1;
        id_rs2 = RW'(rs2); id_rs2_used = u2; id_rd = RW'(rd);
        id_reg_write = w; id_mem_read = ld; redirect = redir;
        enable = en; rst = r;

        fl = redir && en;
        k1 = (v && u1 && rs1 != 0) ? find_prod(rs1) : -1;
        k2 = (v && u2 && rs2 != 0) ? find_prod(rs2) : -1;
        hz = (k1 >= 0 && pipe[k1].ld && k1 + 1 < LOAD_STAGE) ||
             (k2 >= 0 && pipe[k2].ld && k2 + 1 < LOAD_STAGE);
        st = hz && !fl;
        s1 = (k1 >= 0 && k1 < STAGES - 1) ? k1 + 1 : 0;
        s2 = (k2 >= 0 && k2 < STAGES - 1) ? k2 + 1 : 0;

        e.stall = st; e.flush = fl;
        e.b1 = (k1 == STAGES - 1); e.b2 = (k2 == STAGES - 1);
        e.fa = FW'(m_fa); e.fb = FW'(m_fb);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        e.sc = 32'(m_sc); e.fc = 32'(m_fc);
`else
        e.sc = 0; e.fc = 0;
`endif
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else if (en) begin
            ne.v = v && w && rd != 0 && !st && !fl;
            ne.rd = rd; ne.ld = ld;
            pipe.push_front(ne);
            void'(pipe.pop_back());
            if (fl) for (int i = 0; i < BRANCH_STAGE; i++) pipe[i].v = 0;
            m_fa = (st || fl) ? 0 : s1;
            m_fb = (st || fl) ? 0 : s2;
            if (st && m_sc < 64'hFFFF_FFFF) m_sc++;
            if (fl && m_fc < 64'hFFFF_FFFF) m_fc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic nop(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall", 32'(stall), 32'(e.stall));
            check("flush", 32'(flush), 32'(e.flush));
            check("bypass_1", 32'(id_wb_bypass_1), 32'(e.b1));
            check("bypass_2", 32'(id_wb_bypass_2), 32'(e.b2));
            check("ex_fwd_a", 32'(ex_fwd_a), 32'(e.fa));
            check("ex_fwd_b", 32'(ex_fwd_b), 32'(e.fb));
            check("stall_count", stall_count, e.sc);
            check("flush_count", flush_count, e.fc);
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1; enable = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0; id_mem_read = 0;
        redirect = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        nop(3);

        // add x5,x1,x2 ; sub x6,x5,x3
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 1, 0);
        step(1, 5, 1, 3, 1, 6, 1, 0, 0, 1, 0);
        check("dist1_fwd_a", 32'(ex_fwd_a), 32'd1);
        nop(3);

        // Producer reaches WB while consumer is in ID.
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 1, 0);
        nop(2);
        step(1, 5, 1, 3, 1, 6, 1, 0, 0, 1, 0);
        check("dist3_fwd_a", 32'(ex_fwd_a), 32'd0);
        nop(3);

        // ld x7 ; add x8,x7,x7 (stalled once, then forwarded from entry 2)
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 1, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1, 0);
        check("loaduse_bubble_fwd_a", 32'(ex_fwd_a), 32'd0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1, 0);
        check("loaduse_fwd_a", 32'(ex_fwd_a), 32'd2);
        check("loaduse_fwd_b", 32'(ex_fwd_b), 32'd2);
        nop(3);

        // Redirect coinciding with a load-use condition.
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 1, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 1, 1, 0);
        check("flush_fwd_a", 32'(ex_fwd_a), 32'd0);
        nop(3);

        // x0 writer and reader; lui with unused rs1.
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0);
        step(1, 0, 1, 0, 1, 9, 1, 0, 0, 1, 0);
        check("x0_fwd_a", 32'(ex_fwd_a), 32'd0);
        step(1, 9, 0, 0, 0, 10, 1, 0, 0, 1, 0);
        check("lui_fwd_a", 32'(ex_fwd_a), 32'd0);
        nop(3);

        // Reset while a load-use stall is asserted.
        step(1, 1, 1, 0, 0, 7, 1, 1, 0, 1, 0);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1, 1);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1, 0);
        nop(3);

        // Hold for four cycles with a live forwarding select.
        step(1, 1, 1, 2, 1, 5, 1, 0, 0, 1, 0);
        step(1, 5, 1, 3, 1, 6, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 6, 1, 5, 1, 4, 1, 1, i[0], 0, 0);
            check("hold_fwd_a", 32'(ex_fwd_a), 32'd1);
        end
        nop(3);

        // Randomised traffic over a small register window to force hits.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 8) != 0, int'($urandom % 8), ($urandom % 4) != 0,
                 int'($urandom % 8), ($urandom % 4) != 0, int'($urandom % 8),
                 ($urandom % 10) < 7, ($urandom % 10) < 3,
                 ($urandom % 10) == 0, ($urandom % 10) != 0,
                 ($urandom % 100) == 0);
        end

        @(negedge clk); #1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
